// File: rtl/fp_misc_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : fp_misc_pipe
//  Description : Handshaked floating-point miscellaneous unit (NEG, ABS, SIGN,
//                COPYSIGN, MIN, MAX) on a configurable float format with a
//                programmable-depth valid/ready pipeline and a sideband tag.
//  Revision    : 1.0  initial release
// ============================================================================
module fp_misc_pipe #(
    parameter int EXP_W   = 7,
    parameter int MAN_W   = 16,
    parameter int WIDTH   = 1 + EXP_W + MAN_W,
    parameter int LATENCY = 2,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_opcode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    localparam logic [3:0] OP_ABS      = 4'b0101;
    localparam logic [3:0] OP_NEG      = 4'b0110;
    localparam logic [3:0] OP_COPYSIGN = 4'b0111;
    localparam logic [3:0] OP_MIN      = 4'b1000;
    localparam logic [3:0] OP_MAX      = 4'b1001;
    localparam logic [3:0] OP_SIGN     = 4'b1010;

    localparam logic [WIDTH-1:0] CNAN =
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [EXP_W-1:0] BIAS = {1'b0, {(EXP_W-1){1'b1}}};
    localparam logic [WIDTH-2:0] ONE_MAG = {BIAS, {MAN_W{1'b0}}};
    localparam logic [WIDTH-2:0] ZERO_MAG = '0;

    // ------------------------------------------------------------------------
    // Operand field decode
    // ------------------------------------------------------------------------
    logic             a_sign, b_sign;
    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_man, b_man;
    logic             a_zero, b_zero;
    logic             a_nan, b_nan;
    logic [WIDTH-2:0] a_mag, b_mag;
    logic             a_lt_b, a_eq_b;

    assign a_sign = in_a[WIDTH-1];
    assign b_sign = in_b[WIDTH-1];
    assign a_exp  = in_a[WIDTH-2:MAN_W];
    assign b_exp  = in_b[WIDTH-2:MAN_W];
    assign a_man  = in_a[MAN_W-1:0];
    assign b_man  = in_b[MAN_W-1:0];
    assign a_zero = (a_exp == '0);
    assign b_zero = (b_exp == '0);
    assign a_nan  = (&a_exp) && (|a_man);
    assign b_nan  = (&b_exp) && (|b_man);

    // Denormals compare as zero magnitude; the sign still orders -0 below +0.
    assign a_mag  = a_zero ? ZERO_MAG : in_a[WIDTH-2:0];
    assign b_mag  = b_zero ? ZERO_MAG : in_b[WIDTH-2:0];
    assign a_eq_b = (a_sign == b_sign) && (a_mag == b_mag);

    // Sign-magnitude ordering of A against B
    always_comb begin
        a_lt_b = 1'b0;
        if (a_sign != b_sign) begin
            a_lt_b = a_sign;
        end else if (a_sign) begin
            a_lt_b = (a_mag > b_mag);
        end else begin
            a_lt_b = (a_mag < b_mag);
        end
    end

    // ------------------------------------------------------------------------
    // Stage-0 combinational compute (next values for the first stage)
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] res_d;
    logic             ill_d;

    // Operation select; undefined opcodes yield CNaN and flag illegal
    always_comb begin
        res_d = CNAN;
        ill_d = 1'b0;
        case (in_opcode)
            OP_NEG:      res_d = {~a_sign, in_a[WIDTH-2:0]};
            OP_ABS:      res_d = {1'b0, in_a[WIDTH-2:0]};
            OP_COPYSIGN: res_d = {b_sign, in_a[WIDTH-2:0]};
            OP_SIGN: begin
                if (a_nan) begin
                    res_d = CNAN;
                end else if (a_zero) begin
                    res_d = {a_sign, ZERO_MAG};
                end else begin
                    res_d = {a_sign, ONE_MAG};
                end
            end
            OP_MIN, OP_MAX: begin
                if (a_nan && b_nan) begin
                    res_d = CNAN;
                end else if (a_nan) begin
                    res_d = in_b;
                end else if (b_nan) begin
                    res_d = in_a;
                end else if (in_opcode == OP_MIN) begin
                    res_d = (a_lt_b || a_eq_b) ? in_a : in_b;
                end else begin
                    res_d = a_lt_b ? in_b : in_a;
                end
            end
            default: begin
                res_d = CNAN;
                ill_d = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Pipeline: every stage advances together when the tail can move
    // ------------------------------------------------------------------------
    logic                 adv;
    logic [LATENCY-1:0]   valid_q;
    logic [WIDTH-1:0]     res_q [LATENCY];
    logic [TAG_W-1:0]     tag_q [LATENCY];
    logic [LATENCY-1:0]   ill_q;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar g = 0; g < LATENCY; g++) begin : g_stage
        if (g == 0) begin : g_head
            // First stage captures the computed result (or a bubble)
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_q[0] <= 1'b0;
                    res_q[0]   <= '0;
                    tag_q[0]   <= '0;
                    ill_q[0]   <= 1'b0;
                end else if (adv) begin
                    valid_q[0] <= in_valid;
                    res_q[0]   <= res_d;
                    tag_q[0]   <= in_tag;
                    ill_q[0]   <= ill_d;
                end
            end
        end else begin : g_body
            // Later stages take the previous stage's contents on advance
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_q[g] <= 1'b0;
                    res_q[g]   <= '0;
                    tag_q[g]   <= '0;
                    ill_q[g]   <= 1'b0;
                end else if (adv) begin
                    valid_q[g] <= valid_q[g-1];
                    res_q[g]   <= res_q[g-1];
                    tag_q[g]   <= tag_q[g-1];
                    ill_q[g]   <= ill_q[g-1];
                end
            end
        end
    end

    assign out_valid   = valid_q[LATENCY-1];
    assign out_result  = res_q[LATENCY-1];
    assign out_tag     = tag_q[LATENCY-1];
    assign out_illegal = ill_q[LATENCY-1];

endmodule
`default_nettype wire
